// File: rtl/unum4_pack.sv
// unum4 result packer: encodes the divider's normalized mantissa/exponent into a
// minimal-exponent unum4 word (3-cycle pipeline) and buffers words in a small FIFO.
module unum4_pack #(
    parameter int DATA_W    = 32,
    parameter int MAN_MAX_W = 29,
    parameter int EXP_SZ_W  = 4,
    parameter int EXP_MAX_W = 16,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [MAN_MAX_W-1:0]     m_in,
    input  logic [EXP_MAX_W-1:0]     e_in,
    input  logic                     over,
    input  logic                     under,
    input  logic                     div_by_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     fifo_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int EW_W = $clog2(EXP_MAX_W + 1);
    localparam int MW   = MAN_MAX_W + 1;

    // ---------------- S1: capture and exponent width ----------------
    logic [EXP_MAX_W-1:0] e_mag;
    logic [EW_W-1:0]      ew_nxt;

    logic                 s1_valid;
    logic [MAN_MAX_W-1:0] s1_m;
    logic [EXP_MAX_W-1:0] s1_e;
    logic [2:0]           s1_fl;
    logic [EW_W-1:0]      s1_ew;

    // Magnitude of a signed value as seen by its sign-extension: ~e for negatives.
    always_comb begin
        e_mag  = e_in[EXP_MAX_W-1] ? ~e_in : e_in;
        ew_nxt = EW_W'(1);
        for (int unsigned i = 0; i < EXP_MAX_W - 1; i++) begin
            if (e_mag[i]) ew_nxt = EW_W'(i + 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
        if (in_valid) begin
            s1_m  <= m_in;
            s1_e  <= e_in;
            s1_fl <= {div_by_zero, over, under};
            s1_ew <= ew_nxt;
        end
    end

    // ---------------- S2: round, saturate, assemble ----------------
    int                f;
    logic [MW-1:0]     mw, shr, t, sum, top, man;
    logic [DATA_W-1:0] emask, word;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_word;
    logic [2:0]        s2_fl;

    // The appended zero makes the round bit read as 0 when F == MAN_MAX_W.
    always_comb begin
        f     = DATA_W - EXP_SZ_W - int'(s1_ew);
        mw    = {s1_m, 1'b0};
        shr   = mw >> (MAN_MAX_W - f);
        t     = shr >> 1;
        sum   = t + MW'(shr[0]);
        top   = MW'(1) << (f - 1);
        man   = ((sum & top) != (t & top)) ? t : sum;
        emask = (DATA_W'(1) << s1_ew) - DATA_W'(1);
        word  = (DATA_W'(EXP_SZ_W'(s1_ew - EW_W'(1))) << (DATA_W - EXP_SZ_W))
              | ((DATA_W'(s1_e) & emask) << f)
              | DATA_W'(man);
        if (s1_fl[2])                   word = DATA_W'(1) << (DATA_W - 1);
        else if (s1_fl[1])              word = ~(DATA_W'(1) << (DATA_W - 1));
        else if (s1_fl[0] || s1_m == '0) word = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        if (s1_valid) begin
            s2_word <= word;
            s2_fl   <= s1_fl;
        end
    end

    // ---------------- Output FIFO ----------------
    logic [DATA_W+2:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, push, pop;
    logic [DATA_W+2:0] head;

    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == (AW+1)'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = s2_valid && (!full || pop);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_flags = out_valid ? head[DATA_W+2:DATA_W] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s2_fl, s2_word};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (s2_valid && full && !pop) fifo_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unum4_pack.sv
// Scoreboard bench for unum4_pack: driver queues hand-computed words, a negedge
// monitor pops and compares whenever the FIFO head is accepted.
module tb_unum4_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [28:0] m_in = '0;
    logic [15:0] e_in = '0;
    logic        over = 1'b0, under = 1'b0, div_by_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic [2:0]  level;
    logic        fifo_err;

    int applied = 0;
    int miscompares = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    unum4_pack #(.DATA_W(32), .MAN_MAX_W(29), .EXP_SZ_W(4), .EXP_MAX_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .m_in(m_in), .e_in(e_in),
        .over(over), .under(under), .div_by_zero(div_by_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .level(level), .fifo_err(fifo_err)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: a pop happens at the next posedge when valid && ready here.
    always @(negedge clk) begin
        logic [34:0] hd;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL unexpected_word: actual=%0h required=none", out_data);
            end else begin
                hd = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(hd[31:0]));
                chk("out_flags", 64'(out_flags), 64'(hd[34:32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [28:0] m, input logic [15:0] e, input logic [2:0] fl,
                        input logic [31:0] w, input bit keep);
        m_in = m;
        e_in = e;
        {div_by_zero, over, under} = fl;
        in_valid = 1'b1;
        if (keep) exp_q.push_back({fl, w});
        tick();
        in_valid = 1'b0;
        {div_by_zero, over, under} = 3'b000;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        chk(name, 64'(n < 60), 64'(1));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"},  64'(out_data),  64'(0));
        chk({tag, "_out_flags"}, 64'(out_flags), 64'(0));
        chk({tag, "_level"},     64'(level),     64'(0));
        chk({tag, "_fifo_err"},  64'(fifo_err),  64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;

        // Basic encode with latency
        out_ready = 1'b1;
        send(29'h0800_0000, 16'h0000, 3'b000, 32'h0200_0000, 1'b1);
        tick();
        chk("lat_n2_out_valid", 64'(out_valid), 64'(0));
        tick();
        chk("lat_n3_out_valid", 64'(out_valid), 64'(1));
        chk("lat_n3_level", 64'(level), 64'(1));
        chk("lat_n3_out_data", 64'(out_data), 64'h0200_0000);
        wait_drain("drain_basic");

        // Back-to-back directed vectors
        send(29'h0800_0000, 16'h0005, 3'b000, 32'h3540_0000, 1'b1);
        send(29'h1800_0000, 16'h0000, 3'b000, 32'h0600_0000, 1'b1);
        send(29'h0800_0003, 16'h0000, 3'b000, 32'h0200_0001, 1'b1);
        send(29'h0FFF_FFFF, 16'h0000, 3'b000, 32'h03FF_FFFF, 1'b1);
        send(29'h1FFF_FFFF, 16'h0000, 3'b000, 32'h07FF_FFFF, 1'b1);
        send(29'h0800_0000, 16'h7FFF, 3'b000, 32'hF7FF_F400, 1'b1);
        send(29'h0800_0000, 16'hFFFF, 3'b000, 32'h0A00_0000, 1'b1);
        send(29'h0800_0000, 16'hFFFE, 3'b000, 32'h1900_0000, 1'b1);
        send(29'h0800_0000, 16'h0000, 3'b100, 32'h8000_0000, 1'b1);
        send(29'h0800_0000, 16'h0000, 3'b010, 32'h7FFF_FFFF, 1'b1);
        send(29'h0800_0000, 16'h0000, 3'b001, 32'h0000_0000, 1'b1);
        send(29'h0000_0000, 16'h0003, 3'b000, 32'h0000_0000, 1'b1);
        send(29'h0800_0000, 16'h0000, 3'b110, 32'h8000_0000, 1'b1);
        wait_drain("drain_vectors");

        // Backpressure: six results into a four-deep FIFO
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++)
            send(29'h0800_0000 + 29'(k * 4), 16'h0000, 3'b000, 32'h0200_0000 + 32'(k), k <= 4);
        repeat (3) tick();
        chk("bp_level", 64'(level), 64'(4));
        chk("bp_fifo_err", 64'(fifo_err), 64'(1));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_head", 64'(out_data), 64'h0200_0001);
        tick();
        chk("bp_head_hold", 64'(out_data), 64'h0200_0001);
        out_ready = 1'b1;
        wait_drain("drain_bp");
        chk("bp_empty_valid", 64'(out_valid), 64'(0));
        chk("bp_empty_level", 64'(level), 64'(0));
        chk("bp_err_sticky", 64'(fifo_err), 64'(1));

        // Full with simultaneous pop and write
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("rst_clears_err", 64'(fifo_err), 64'(0));
        for (int k = 1; k <= 4; k++)
            send(29'h0800_0000 + 29'(k * 4), 16'h0000, 3'b000, 32'h0200_0000 + 32'(k), 1'b1);
        repeat (3) tick();
        chk("full_level", 64'(level), 64'(4));
        send(29'h0800_0000, 16'h0005, 3'b000, 32'h3540_0000, 1'b1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("popwr_level", 64'(level), 64'(4));
        chk("popwr_fifo_err", 64'(fifo_err), 64'(0));
        out_ready = 1'b1;
        wait_drain("drain_popwr");
        chk("popwr_empty_level", 64'(level), 64'(0));

        // Reset mid-stream: FIFO full, one drop, one result in flight
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++)
            send(29'h0800_0000 + 29'(k * 4), 16'h0001, 3'b000, 32'h0, 1'b0);
        tick();
        chk("pre_rst_fifo_err", 64'(fifo_err), 64'(1));
        chk("pre_rst_level", 64'(level), 64'(4));
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk_zero("midrst");
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        chk("post_rst_level", 64'(level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
